barrel_shift_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `barrel_shifter` instance among `NUM_REQ` requesters. Each requester presents a shift job (data, amount, direction) on a valid/ready port. The block grants one job per cycle, drives the shared shifter, and registers the result with the winner's ID on a single valid/ready output port. It sits between the shift clients and the shifter, so only one shifter is instantiated per cluster.

---
 rtl/barrel_pkg.sv | 10 +
 rtl/barrel_shift_arbiter_if.sv | 38 +++
 rtl/barrel_shift_arbiter_rr.sv | 30 +++
 rtl/barrel_shifter.sv | 18 +
 rtl/barrel_shift_arbiter.sv | 75 +++++++
 tb/tb_barrel_shift_arbiter.sv | 247 ++++++++++++++++++++++++
 6 files changed

// File: rtl/barrel_pkg.sv
// Shared constants for the barrel shifter cluster.
// Shift direction encodings and the default data width.
package barrel_pkg;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/barrel_shift_arbiter_if.sv
// Job/result bus between shift clients and the arbiter.
// master: clients/consumer side; slave: arbiter side.
interface barrel_shift_arbiter_if
  import barrel_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = 4
);
  localparam int SW  = $clog2(DATA_WIDTH);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_dir;
  logic [NUM_REQ*SW-1:0]         req_shift;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out_data;
  logic [IDW-1:0]                out_id;

  modport master (
    output req_valid, req_dir,
    output req_shift, req_data,
    output out_ready,
    input  req_ready, out_valid,
    input  out_data, out_id
  );

  modport slave (
    input  req_valid, req_dir,
    input  req_shift, req_data,
    input  out_ready,
    output req_ready, out_valid,
    output out_data, out_id
  );

endinterface

// File: rtl/barrel_shift_arbiter_rr.sv
// Combinational round-robin grant starting at ptr.
// Ports: req, ptr in; one-hot grant, grant_id, any out.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id,
  output logic               any
);

  always_comb begin
    int idx;
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any       = 1'b1;
        grant[idx] = 1'b1;
        grant_id  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/barrel_shifter.sv
// Logical barrel shifter: rbarl=0 shifts right, 1 left.
// Ports: data_in, shift amount, rbarl direction, data_out.
module barrel_shifter
  import barrel_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  localparam int SW = $clog2(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [SW-1:0]         shift,
  input  logic                  rbarl,
  output logic [DATA_WIDTH-1:0] data_out
);

  assign data_out = (rbarl == DIR_LEFT) ?
    (data_in << shift) : (data_in >> shift);

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Shares one barrel_shifter among NUM_REQ requesters.
// Ports: clk, rst_n, bus (job ports in, result port out).
module barrel_shift_arbiter
  import barrel_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REQ    = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  barrel_shift_arbiter_if.slave bus
);

  localparam int SW  = $clog2(DATA_WIDTH);
  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0]        ptr;
  logic [IDW-1:0]        ptr_nxt;
  logic [IDW-1:0]        grant_id;
  logic [NUM_REQ-1:0]    grant;
  logic                  any;
  logic                  can_accept;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sh_in;
  logic [DATA_WIDTH-1:0] sh_out;
  logic [SW-1:0]         sh_amt;
  logic                  sh_dir;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (bus.req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (any)
  );

  assign can_accept = !bus.out_valid || bus.out_ready;
  assign accept     = any && can_accept;

  // rst_n gate keeps clients from seeing a grant
  // while the result register is held in reset.
  assign bus.req_ready =
    (rst_n && can_accept) ? grant : '0;

  assign sh_in  = bus.req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign sh_amt = bus.req_shift[grant_id*SW +: SW];
  assign sh_dir = bus.req_dir[grant_id];

  barrel_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shift (
    .data_in  (sh_in),
    .shift    (sh_amt),
    .rbarl    (sh_dir),
    .data_out (sh_out)
  );

  assign ptr_nxt = (grant_id == IDW'(NUM_REQ-1)) ?
    '0 : grant_id + IDW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_id    <= '0;
    end else if (accept) begin
      ptr          <= ptr_nxt;
      bus.out_valid <= 1'b1;
      bus.out_data  <= sh_out;
      bus.out_id    <= grant_id;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed bench for barrel_shift_arbiter.
// Vector table plus multi-cycle handshake sequences.
module tb_barrel_shift_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int SW = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  barrel_shift_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bif ();

  barrel_shift_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       dir;
    logic [2:0] sh;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [7:0] model(
    input logic [7:0] d, input logic [2:0] sh, input logic dir);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (dir) begin
        if (i >= int'(sh)) r[i] = d[i-int'(sh)];
      end else begin
        if (i + int'(sh) < 8) r[i] = d[i+int'(sh)];
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_job(input int id, input logic dir,
                         input logic [2:0] sh, input logic [7:0] d);
    bif.req_dir[id]             = dir;
    bif.req_shift[id*SW +: SW]  = sh;
    bif.req_data[id*DW +: DW]   = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] held_data;
  logic [7:0] jd [NR];

  initial begin
    checks = 0;
    errors = 0;
    tbl[0] = '{0, 1'b0, 3'd1, 8'hA5, 8'h52};
    tbl[1] = '{1, 1'b1, 3'd1, 8'hA5, 8'h4A};
    tbl[2] = '{2, 1'b0, 3'd0, 8'hA5, 8'hA5};
    tbl[3] = '{3, 1'b1, 3'd7, 8'h01, 8'h80};
    tbl[4] = '{0, 1'b0, 3'd7, 8'h80, 8'h01};
    tbl[5] = '{1, 1'b1, 3'd4, 8'h3C, 8'hC0};
    tbl[6] = '{2, 1'b0, 3'd4, 8'h3C, 8'h03};
    tbl[7] = '{3, 1'b0, 3'd3, 8'hFF, 8'h1F};

    rst_n         = 1'b0;
    bif.req_valid = '0;
    bif.req_dir   = '0;
    bif.req_shift = '0;
    bif.req_data  = '0;
    bif.out_ready = 1'b1;

    // reset state, with requests pending
    bif.req_valid = 4'hF;
    #1;
    chk("rst_out_valid", 32'(bif.out_valid), 0);
    chk("rst_out_data", 32'(bif.out_data), 0);
    chk("rst_out_id", 32'(bif.out_id), 0);
    chk("rst_req_ready", 32'(bif.req_ready), 0);
    step();
    chk("rst_hold_ready", 32'(bif.req_ready), 0);
    bif.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // single request on requester 2
    set_job(2, 1'b0, 3'd0, 8'hA5);
    bif.req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", 32'(bif.req_ready), 32'(4'b0100));
    step();
    bif.req_valid = '0;
    chk("single_valid", 32'(bif.out_valid), 1);
    chk("single_data", 32'(bif.out_data), 32'h A5);
    chk("single_id", 32'(bif.out_id), 2);
    step();
    chk("single_drain", 32'(bif.out_valid), 0);

    // vector table: one requester at a time
    for (int v = 0; v < 8; v++) begin
      set_job(tbl[v].id, tbl[v].dir, tbl[v].sh, tbl[v].data);
      bif.req_valid = 4'(1 << tbl[v].id);
      @(negedge clk);
      chk("tbl_ready", 32'(bif.req_ready), 32'(1 << tbl[v].id));
      step();
      bif.req_valid = '0;
      chk("tbl_valid", 32'(bif.out_valid), 1);
      chk("tbl_data", 32'(bif.out_data), 32'(tbl[v].exp));
      chk("tbl_id", 32'(bif.out_id), 32'(tbl[v].id));
    end
    step();
    chk("tbl_drain", 32'(bif.out_valid), 0);

    // full contention, ptr is back at 0
    for (int i = 0; i < NR; i++) begin
      jd[i] = 8'(8'h11 * (i + 1));
      set_job(i, 1'(i & 1), 3'(i), jd[i]);
    end
    bif.req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("cont_ready", 32'(bif.req_ready), 32'(1 << (k % NR)));
      step();
      chk("cont_valid", 32'(bif.out_valid), 1);
      chk("cont_id", 32'(bif.out_id), 32'(k % NR));
      chk("cont_data", 32'(bif.out_data),
          32'(model(jd[k%NR], 3'(k % NR), 1'((k % NR) & 1))));
    end
    bif.req_valid = '0;
    step();

    // pointer rotation: grant 1, then 1 and 3 contend
    set_job(1, 1'b0, 3'd2, 8'hF0);
    set_job(3, 1'b1, 3'd2, 8'h0F);
    bif.req_valid = 4'b0010;
    step();
    chk("rot_first_id", 32'(bif.out_id), 1);
    bif.req_valid = 4'b1010;
    @(negedge clk);
    chk("rot_ready3", 32'(bif.req_ready), 32'(4'b1000));
    step();
    chk("rot_id3", 32'(bif.out_id), 3);
    chk("rot_data3", 32'(bif.out_data), 32'h3C);
    bif.req_valid = 4'b0010;
    @(negedge clk);
    chk("rot_ready1", 32'(bif.req_ready), 32'(4'b0010));
    step();
    chk("rot_id1", 32'(bif.out_id), 1);
    chk("rot_data1", 32'(bif.out_data), 32'h3C);
    bif.req_valid = '0;
    step();
    chk("rot_drain", 32'(bif.out_valid), 0);

    // backpressure
    bif.out_ready = 1'b0;
    set_job(2, 1'b0, 3'd1, 8'h5A);
    bif.req_valid = 4'b0100;
    step();
    chk("bp_load_valid", 32'(bif.out_valid), 1);
    chk("bp_load_id", 32'(bif.out_id), 2);
    held_data = 8'h2D;
    chk("bp_load_data", 32'(bif.out_data), 32'(held_data));
    set_job(0, 1'b1, 3'd2, 8'hC3);
    bif.req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_ready", 32'(bif.req_ready), 0);
      step();
      chk("bp_valid", 32'(bif.out_valid), 1);
      chk("bp_id", 32'(bif.out_id), 2);
      chk("bp_data", 32'(bif.out_data), 32'(held_data));
    end
    bif.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(bif.req_ready), 32'(4'b0001));
    step();
    bif.req_valid = '0;
    chk("bp_new_valid", 32'(bif.out_valid), 1);
    chk("bp_new_id", 32'(bif.out_id), 0);
    chk("bp_new_data", 32'(bif.out_data), 32'h0C);

    // reset mid-stream, ptr was 1
    set_job(2, 1'b0, 3'd0, 8'h77);
    set_job(0, 1'b1, 3'd0, 8'h99);
    bif.req_valid = 4'b0101;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(bif.out_valid), 0);
    chk("mrst_data", 32'(bif.out_data), 0);
    chk("mrst_id", 32'(bif.out_id), 0);
    chk("mrst_ready", 32'(bif.req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_grant0", 32'(bif.req_ready), 32'(4'b0001));
    step();
    chk("mrst_id0", 32'(bif.out_id), 0);
    chk("mrst_data0", 32'(bif.out_data), 32'h99);
    bif.req_valid = '0;
    step();

    // data sweep
    for (int id = 0; id < NR; id++) begin
      for (int dir = 0; dir < 2; dir++) begin
        for (int sh = 0; sh < 8; sh++) begin
          logic [7:0] d;
          d = 8'($random);
          set_job(id, 1'(dir), 3'(sh), d);
          bif.req_valid = 4'(1 << id);
          step();
          bif.req_valid = '0;
          chk("sweep_data", 32'(bif.out_data),
              32'(model(d, 3'(sh), 1'(dir))));
          chk("sweep_id", 32'(bif.out_id), 32'(id));
        end
      end
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
